// File: rtl/riscv_mem_stage.sv
// Memory-access pipeline stage: registers EX results, tracks one outstanding dmem access,
// aligns/extends load data and merges bus faults. Optional ack watchdog: RV_MEM_ACK_TIMEOUT_EN.
package riscv_mem_pkg;
  typedef struct packed {
    logic [31:0] instr;
    logic        bubble;
    logic        retired;
    logic        dbg;
  } instruction_t;

  // cause is one-hot, indexed by the RISC-V exception code
  typedef struct packed {
    logic        any;
    logic [15:0] cause;
  } interrupts_exceptions_t;

  localparam int unsigned CAUSE_LOAD_ACCESS_FAULT  = 5;
  localparam int unsigned CAUSE_STORE_ACCESS_FAULT = 7;
endpackage

module riscv_mem_stage
  import riscv_mem_pkg::*;
#(
  parameter int unsigned     XLEN    = 32,
  parameter logic [XLEN-1:0] PC_INIT = 'h200
`ifdef RV_MEM_ACK_TIMEOUT_EN
  , parameter int unsigned   ACK_TIMEOUT = 255
`endif
) (
  input  logic                   rst_ni,
  input  logic                   clk_i,
  input  logic                   wb_stall_i,
  output logic                   mem_stall_o,
  input  logic [XLEN-1:0]        ex_pc_i,
  input  instruction_t           ex_insn_i,
  input  interrupts_exceptions_t ex_exceptions_i,
  input  interrupts_exceptions_t wb_exceptions_i,
  input  logic [XLEN-1:0]        ex_r_i,
  input  logic                   ex_dmem_req_i,
  input  logic                   ex_dmem_we_i,
  input  logic [XLEN-1:0]        ex_dmem_adr_i,
  input  logic [XLEN-1:0]        dmem_q_i,
  input  logic                   dmem_ack_i,
  input  logic                   dmem_err_i,
  output logic [XLEN-1:0]        mem_pc_o,
  output instruction_t           mem_insn_o,
  output interrupts_exceptions_t mem_exceptions_o,
  output logic [XLEN-1:0]        mem_r_o,
  output logic [XLEN-1:0]        mem_ld_o
);

  localparam int unsigned LaneW = $clog2(XLEN / 8);

  typedef enum logic {StIdle, StWait} state_e;

  state_e           state_q;
  logic             flushed_q;
  logic             we_q;
  logic [2:0]       f3_q;
  logic [LaneW-1:0] lane_q;

  logic             in_wait, timeout, done, fault, discard, capture, flush;
  logic [3:0]       fault_cause;
  logic [XLEN-1:0]  shifted, ld_ext;
  logic             unused_adr;

  assign unused_adr = ^ex_dmem_adr_i[XLEN-1:LaneW];
  assign in_wait    = (state_q == StWait);

`ifdef RV_MEM_ACK_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);
  logic [CntW-1:0] cnt_q;

  assign timeout = in_wait && (cnt_q == CntW'(ACK_TIMEOUT));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (in_wait && !done) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign done        = in_wait & (dmem_ack_i | dmem_err_i | timeout);
  assign mem_stall_o = wb_stall_i | (in_wait & ~done);
  assign capture     = ~mem_stall_o;
  assign flush       = ex_exceptions_i.any | mem_exceptions_o.any | wb_exceptions_i.any;
  // A flush seen while the bus is busy only takes effect once the access completes.
  assign discard     = flushed_q | wb_exceptions_i.any;
  // An error wins over a simultaneous ack; a late ack rescues a timed-out access.
  assign fault       = dmem_err_i | (timeout & ~dmem_ack_i);
  assign fault_cause = we_q ? 4'(CAUSE_STORE_ACCESS_FAULT) : 4'(CAUSE_LOAD_ACCESS_FAULT);

  always_comb begin
    shifted = dmem_q_i >> {lane_q, 3'b000};
    case (f3_q)
      3'b000:  ld_ext = XLEN'($signed(shifted[7:0]));
      3'b001:  ld_ext = XLEN'($signed(shifted[15:0]));
      3'b010:  ld_ext = XLEN'($signed(shifted[31:0]));
      3'b100:  ld_ext = XLEN'(shifted[7:0]);
      3'b101:  ld_ext = XLEN'(shifted[15:0]);
      3'b110:  ld_ext = XLEN'(shifted[31:0]);
      default: ld_ext = shifted;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= StIdle;
      flushed_q        <= 1'b0;
      we_q             <= 1'b0;
      f3_q             <= 3'b000;
      lane_q           <= '0;
      mem_pc_o         <= PC_INIT;
      mem_insn_o       <= '{instr: '0, bubble: 1'b1, retired: 1'b0, dbg: 1'b0};
      mem_exceptions_o <= '0;
      mem_r_o          <= '0;
      mem_ld_o         <= '0;
    end else begin
      if (capture) begin
        mem_pc_o         <= ex_pc_i;
        mem_insn_o       <= ex_insn_i;
        mem_exceptions_o <= ex_exceptions_i;
        mem_r_o          <= ex_r_i;
        if (flush) begin
          mem_insn_o.bubble  <= 1'b1;
          mem_insn_o.retired <= 1'b0;
          if (wb_exceptions_i.any) mem_exceptions_o <= '0;
        end
      end

      if (done) begin
        if (discard) begin
          mem_insn_o.bubble  <= 1'b1;
          mem_insn_o.retired <= 1'b0;
          mem_exceptions_o   <= '0;
        end else if (fault) begin
          mem_insn_o.bubble                   <= 1'b1;
          mem_insn_o.retired                  <= 1'b0;
          mem_exceptions_o.any                <= 1'b1;
          mem_exceptions_o.cause[fault_cause] <= 1'b1;
        end else if (!we_q) begin
          mem_ld_o <= ld_ext;
        end
      end

      if (capture && ex_dmem_req_i) begin
        state_q   <= StWait;
        we_q      <= ex_dmem_we_i;
        f3_q      <= ex_insn_i.instr[14:12];
        lane_q    <= ex_dmem_adr_i[LaneW-1:0];
        flushed_q <= wb_exceptions_i.any;
      end else if (done) begin
        state_q   <= StIdle;
        flushed_q <= 1'b0;
      end else if (in_wait && wb_exceptions_i.any) begin
        flushed_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_riscv_mem_stage.sv
// Scoreboard bench for riscv_mem_stage: driver pushes expected completions, monitor checks them.
module tb_riscv_mem_stage;
  import riscv_mem_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   wb_stall, mem_stall;
  logic [31:0]            ex_pc, ex_r, ex_adr, dmem_q, mem_pc, mem_r, mem_ld;
  instruction_t           ex_insn, mem_insn;
  interrupts_exceptions_t ex_exc, wb_exc, mem_exc;
  logic                   ex_req, ex_we, dmem_ack, dmem_err;

  always #5 clk = ~clk;

  riscv_mem_stage #(
    .XLEN(32)
`ifdef RV_MEM_ACK_TIMEOUT_EN
    , .ACK_TIMEOUT(8)
`endif
  ) dut (
    .rst_ni(rst_n), .clk_i(clk), .wb_stall_i(wb_stall), .mem_stall_o(mem_stall),
    .ex_pc_i(ex_pc), .ex_insn_i(ex_insn), .ex_exceptions_i(ex_exc),
    .wb_exceptions_i(wb_exc), .ex_r_i(ex_r), .ex_dmem_req_i(ex_req),
    .ex_dmem_we_i(ex_we), .ex_dmem_adr_i(ex_adr), .dmem_q_i(dmem_q),
    .dmem_ack_i(dmem_ack), .dmem_err_i(dmem_err), .mem_pc_o(mem_pc),
    .mem_insn_o(mem_insn), .mem_exceptions_o(mem_exc), .mem_r_o(mem_r), .mem_ld_o(mem_ld)
  );

  typedef struct {
    string       name;
    int          stall;      // stalled cycles since previous completion
    logic        stall_now;
    logic [31:0] ld;
    logic [16:0] exc;
    logic        bubble;
    bit          chk_r;
    logic [31:0] r;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0, n_pass = 0, n_done = 0, n_seen = 0;
  logic [31:0] last_ld = '0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, got, exp);
    else n_pass++;
  endtask

  // Reference load: pick bytes by arithmetic, then two's-complement adjust for signed loads.
  function automatic logic [31:0] ref_load(input logic [31:0] q, input logic [2:0] f3,
                                           input logic [1:0] lane);
    int     nbytes;
    longint v, span;
    nbytes = 1 << f3[1:0];
    span   = longint'(1) << (8 * nbytes);
    v      = longint'({32'b0, q}) >> (8 * lane);
    v      = v % span;
    if (!f3[2] && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  function automatic instruction_t mk_insn(input bit st, input logic [2:0] f3);
    instruction_t i;
    i.instr   = {17'h0, f3, 5'h0, st ? 7'b0100011 : 7'b0000011};
    i.bubble  = 1'b0;
    i.retired = 1'b1;
    i.dbg     = 1'b0;
    return i;
  endfunction

  localparam instruction_t Nop = '{instr: 32'h13, bubble: 1'b0, retired: 1'b1, dbg: 1'b0};

  initial begin : monitor
    int   cnt;
    exp_t e;
    cnt = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        cnt = 0;
      end else if (n_seen < n_done) begin
        n_seen++;
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL sb_underflow: got empty queue, expected an entry");
        end else begin
          e = sb.pop_front();
          chk({e.name, "_stall_cycles"}, cnt, e.stall);
          chk({e.name, "_stall_now"}, {31'b0, mem_stall}, {31'b0, e.stall_now});
          chk({e.name, "_ld"}, mem_ld, e.ld);
          chk({e.name, "_exc"}, {15'b0, mem_exc}, {15'b0, e.exc});
          chk({e.name, "_bubble"}, {31'b0, mem_insn.bubble}, {31'b0, e.bubble});
          if (e.chk_r) chk({e.name, "_r"}, mem_r, e.r);
        end
        cnt = 0;
      end else if (mem_stall) begin
        cnt++;
      end
    end
  end

  // w: WAIT cycles before response; resp: 0 ack, 1 err, 2 none; k: wb_stall cycles from response;
  // fl: WB flush pulse in the first WAIT cycle (needs w >= 1).
  task automatic txn(input string nm, input bit st, input logic [2:0] f3, input logic [31:0] adr,
                     input logic [31:0] q, input int w, input int resp, input int k, input bit fl);
    exp_t        e;
    logic [31:0] r;
    r = $urandom;
    @(negedge clk);
    ex_insn = mk_insn(st, f3); ex_pc = $urandom; ex_r = r;
    ex_req = 1'b1; ex_we = st; ex_adr = adr;
    @(negedge clk);
    ex_req = 1'b0; ex_insn = Nop; ex_r = $urandom; ex_pc = $urandom;
    for (int i = 0; i < w; i++) begin
      wb_exc.any = fl && (i == 0);
      @(negedge clk);
    end
    wb_exc   = '0;
    dmem_q   = q;
    dmem_ack = (resp == 0);
    dmem_err = (resp == 1);
    wb_stall = (k > 0);
    @(negedge clk);
    dmem_ack = 1'b0; dmem_err = 1'b0; wb_stall = (k > 1);

    e.name      = nm;
    e.stall     = w + ((k > 0) ? 1 : 0);
    e.stall_now = (k > 1);
    if (fl || resp == 0) e.exc = '0;
    else e.exc = {1'b1, st ? 16'h0080 : 16'h0020};
    if (!st && resp == 0 && !fl) last_ld = ref_load(q, f3, adr[1:0]);
    e.ld     = last_ld;
    e.bubble = fl || (resp != 0);
    e.chk_r  = (k > 0);
    e.r      = r;
    sb.push_back(e);
    n_done++;

    if (k > 0) begin
      for (int m = 2; m <= k; m++) begin
        @(negedge clk);
        wb_stall = (m < k);
      end
      repeat (2) @(negedge clk);
      e.name      = {nm, "_after"};
      e.stall     = (k > 2) ? k - 2 : 0;
      e.stall_now = 1'b0;
      e.exc       = '0;
      e.ld        = last_ld;
      e.bubble    = 1'b0;
      e.chk_r     = 1'b0;
      sb.push_back(e);
      n_done++;
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish within 2 ms");
    $fatal(1);
  end

  initial begin : driver
    bit          st;
    logic [2:0]  f3;
    logic [1:0]  lane;
    int          w, resp, k;
    bit          fl;
    rst_n = 1'b0; wb_stall = 1'b0; ex_pc = '0; ex_r = '0; ex_adr = '0; dmem_q = '0;
    ex_insn = Nop; ex_exc = '0; wb_exc = '0; ex_req = 1'b0; ex_we = 1'b0;
    dmem_ack = 1'b0; dmem_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pc", mem_pc, 32'h200);
    chk("rst_bubble", {31'b0, mem_insn.bubble}, 32'd1);
    chk("rst_retired_dbg", {30'b0, mem_insn.retired, mem_insn.dbg}, 32'd0);
    chk("rst_exc", {15'b0, mem_exc}, 32'd0);
    chk("rst_r", mem_r, 32'd0);
    chk("rst_ld", mem_ld, 32'd0);
    chk("rst_stall", {31'b0, mem_stall}, 32'd0);
    rst_n = 1'b1;

    txn("t1_lw", 1'b0, 3'b010, 32'h1000, 32'h8000_00F0, 0, 0, 0, 1'b0);
    txn("t2_lb", 1'b0, 3'b000, 32'h1003, 32'h8012_3456, 3, 0, 0, 1'b0);
    txn("t2_lbu", 1'b0, 3'b100, 32'h1003, 32'h8012_3456, 3, 0, 0, 1'b0);
    txn("t3_sw_err", 1'b1, 3'b010, 32'h2000, 32'h0, 1, 1, 0, 1'b0);
    txn("t4_flush", 1'b0, 3'b010, 32'h3000, 32'h1234_5678, 4, 0, 0, 1'b1);
    txn("t5_ack_wbstall", 1'b0, 3'b010, 32'h4000, 32'hCAFE_F00D, 0, 0, 2, 1'b0);
    txn("lh_hi", 1'b0, 3'b001, 32'h5002, 32'h9ABC_0000, 2, 0, 0, 1'b0);
    txn("lw_err", 1'b0, 3'b010, 32'h6000, 32'h0, 2, 1, 1, 1'b0);

    // Stray ack while idle must be ignored.
    @(negedge clk);
    dmem_ack = 1'b1; dmem_q = 32'hDEAD_BEEF;
    @(negedge clk);
    dmem_ack = 1'b0;
    @(negedge clk);
    #2;
    chk("idle_ack_ld", mem_ld, last_ld);
    chk("idle_ack_stall", {31'b0, mem_stall}, 32'd0);

    for (int n = 0; n < 40; n++) begin
      st = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, st ? 2 : 4))
        0:       f3 = 3'b000;
        1:       f3 = 3'b001;
        2:       f3 = 3'b010;
        3:       f3 = 3'b100;
        default: f3 = 3'b101;
      endcase
      lane = 2'($urandom_range(0, 3));
      if (f3[0]) lane[0] = 1'b0;
      if (f3[1]) lane = 2'b00;
      w    = $urandom_range(0, 4);
      resp = ($urandom_range(0, 7) == 0) ? 1 : 0;
      k    = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
      fl   = (w >= 1) && ($urandom_range(0, 7) == 0);
      txn($sformatf("rnd%0d", n), st, f3, {$urandom_range(0, 255), 8'h0, 6'h0, lane},
          $urandom, w, resp, k, fl);
    end

`ifdef RV_MEM_ACK_TIMEOUT_EN
    txn("t6_timeout", 1'b0, 3'b001, 32'h7000, 32'h0, 8, 2, 0, 1'b0);
`else
    txn("t6_no_timeout", 1'b0, 3'b001, 32'h7000, 32'h0000_8001, 100, 0, 0, 1'b0);
`endif

    // Reset in the middle of WAIT, then a late ack that must be ignored.
    @(negedge clk);
    ex_insn = mk_insn(1'b0, 3'b010); ex_req = 1'b1; ex_we = 1'b0; ex_adr = 32'h8000;
    @(negedge clk);
    ex_req = 1'b0; ex_insn = Nop;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    dmem_ack = 1'b1; dmem_q = 32'h5555_AAAA;
    @(negedge clk);
    dmem_ack = 1'b0;
    #2;
    chk("late_ack_ld", mem_ld, 32'd0);
    chk("late_ack_stall", {31'b0, mem_stall}, 32'd0);
    last_ld = '0;

    repeat (3) @(negedge clk);
    chk("sb_drain", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
